// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC/nPC pair with branch delay slot, IF/ID latch, stall/squash handling.
// Optional performance counters are enabled by defining IF_PERF_COUNTERS_EN.
module instruction_fetch_unit #(
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              id_ready,
  input  logic              redirect,
  input  logic [31:0]       redirect_target,
  input  logic              squash,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc8,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HOLD} state_t;

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc8;

  logic        w_active;
  logic        w_advance;
  logic [31:0] w_target;
  logic        w_unused_bits;

  assign w_active      = (r_state != ST_BOOT);
  assign w_advance     = w_active && id_ready;
  // Targets are word aligned; the two low bits of the request are dropped.
  assign w_target      = {redirect_target[31:2], 2'b00};
  assign w_unused_bits = ^redirect_target[1:0];

  assign imem_addr = r_pc[ADDR_W-1:0];
  assign if_valid  = r_valid;
  assign if_instr  = r_instr;
  assign if_pc     = r_if_pc;
  assign if_pc8    = r_if_pc8;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_BOOT;
      r_pc     <= RESET_PC_AL;
      r_npc    <= RESET_PC_AL + 32'd4;
      r_valid  <= 1'b0;
      r_instr  <= NOP_WORD;
      r_if_pc  <= 32'd0;
      r_if_pc8 <= 32'd8;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN, ST_HOLD: begin
          if (id_ready) begin
            r_state  <= ST_RUN;
            r_if_pc  <= r_pc;
            r_if_pc8 <= r_pc + 32'd8;
            if (squash) begin
              r_instr <= NOP_WORD;
              r_valid <= 1'b0;
            end else begin
              r_instr <= imem_data;
              r_valid <= 1'b1;
            end
            // Redirect only retargets nPC, so the delay slot at the old nPC is fetched first.
            r_pc  <= r_npc;
            r_npc <= redirect ? w_target : (r_npc + 32'd4);
          end else begin
            r_state <= ST_HOLD;
            if (squash) begin
              r_instr <= NOP_WORD;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else begin
      if (w_advance && !squash && (r_fetch_count != 32'hFFFF_FFFF))
        r_fetch_count <= r_fetch_count + 32'd1;
      if (w_active && !id_ready && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`else
  assign fetch_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: table-driven run plus reset-mid-redirect and PC wrap sequences.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic [8:0]  imem_addr;
  logic [31:0] imem_data;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        squash;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc8;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:127];

  instruction_fetch_unit #(
    .ADDR_W(9),
    .RESET_PC(32'h0000_0000),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .id_ready(id_ready),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .squash(squash),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_pc8(if_pc8),
    .fetch_count(fetch_count),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[8:2]];

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        sq;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [8:0]  exp_addr;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rdy, input logic redir, input logic [31:0] tgt,
                              input logic sq, input logic ev, input logic [31:0] ei,
                              input logic [31:0] ep, input logic [8:0] ea);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.tgt = tgt; v.sq = sq;
    v.exp_valid = ev; v.exp_instr = ei; v.exp_pc = ep; v.exp_addr = ea;
    return v;
  endfunction

  task automatic chk_counters(input string tag, input logic [31:0] ef, input logic [31:0] es);
`ifdef IF_PERF_COUNTERS_EN
    chk({tag, " fetch_count"}, fetch_count, ef);
    chk({tag, " stall_count"}, stall_count, es);
`else
    chk({tag, " fetch_count"}, fetch_count, 32'd0 & ef);
    chk({tag, " stall_count"}, stall_count, 32'd0 & es);
`endif
  endtask

  initial begin
    logic [31:0] exp_fetch;
    logic [31:0] exp_stall;

    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 | (i * 4);
    mem[0] = 32'h2001_0005;
    mem[1] = 32'h2002_0003;
    mem[2] = 32'h0022_1820;

    //            rdy redir tgt          sq valid instr          pc             addr
    vecs[0]  = mk(1, 0, 32'h0,        0, 0, 32'h0000_0000, 32'h0000_0000, 9'h000);
    vecs[1]  = mk(1, 0, 32'h0,        0, 1, 32'h2001_0005, 32'h0000_0000, 9'h004);
    vecs[2]  = mk(1, 0, 32'h0,        0, 1, 32'h2002_0003, 32'h0000_0004, 9'h008);
    vecs[3]  = mk(0, 0, 32'h0,        0, 1, 32'h2002_0003, 32'h0000_0004, 9'h008);
    vecs[4]  = mk(0, 0, 32'h0,        0, 1, 32'h2002_0003, 32'h0000_0004, 9'h008);
    vecs[5]  = mk(0, 0, 32'h0,        0, 1, 32'h2002_0003, 32'h0000_0004, 9'h008);
    vecs[6]  = mk(1, 0, 32'h0,        0, 1, 32'h0022_1820, 32'h0000_0008, 9'h00C);
    vecs[7]  = mk(1, 0, 32'h0,        0, 1, 32'hA500_000C, 32'h0000_000C, 9'h010);
    vecs[8]  = mk(1, 1, 32'h40,       0, 1, 32'hA500_0010, 32'h0000_0010, 9'h014);
    vecs[9]  = mk(1, 0, 32'h0,        0, 1, 32'hA500_0014, 32'h0000_0014, 9'h040);
    vecs[10] = mk(1, 0, 32'h0,        0, 1, 32'hA500_0040, 32'h0000_0040, 9'h044);
    vecs[11] = mk(1, 0, 32'h0,        0, 1, 32'hA500_0044, 32'h0000_0044, 9'h048);
    vecs[12] = mk(0, 1, 32'h100,      0, 1, 32'hA500_0044, 32'h0000_0044, 9'h048);
    vecs[13] = mk(1, 0, 32'h0,        0, 1, 32'hA500_0048, 32'h0000_0048, 9'h04C);
    vecs[14] = mk(1, 0, 32'h0,        0, 1, 32'hA500_004C, 32'h0000_004C, 9'h050);
    vecs[15] = mk(1, 1, 32'h23,       0, 1, 32'hA500_0050, 32'h0000_0050, 9'h054);
    vecs[16] = mk(1, 0, 32'h0,        0, 1, 32'hA500_0054, 32'h0000_0054, 9'h020);
    vecs[17] = mk(1, 0, 32'h0,        1, 0, 32'h0000_0000, 32'h0000_0020, 9'h024);
    vecs[18] = mk(1, 0, 32'h0,        0, 1, 32'hA500_0024, 32'h0000_0024, 9'h028);
    vecs[19] = mk(0, 0, 32'h0,        1, 0, 32'h0000_0000, 32'h0000_0024, 9'h028);
    vecs[20] = mk(1, 0, 32'h0,        0, 1, 32'hA500_0028, 32'h0000_0028, 9'h02C);

    reset = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_target = 32'h0; squash = 1'b0;
    step();
    $display("reset: valid=%0b instr=%08h pc=%08h pc8=%08h addr=%03h", if_valid, if_instr, if_pc, if_pc8, imem_addr);
    chk("reset if_valid", {31'd0, if_valid}, 32'd0);
    chk("reset if_instr", if_instr, 32'h0);
    chk("reset if_pc", if_pc, 32'h0);
    chk("reset if_pc8", if_pc8, 32'h8);
    chk("reset imem_addr", {23'd0, imem_addr}, 32'h0);
    chk_counters("reset", 32'd0, 32'd0);

    reset = 1'b0;
    exp_fetch = 0;
    exp_stall = 0;
    for (int i = 0; i < 21; i++) begin
      id_ready = vecs[i].rdy; redirect = vecs[i].redir;
      redirect_target = vecs[i].tgt; squash = vecs[i].sq;
      step();
      if (i > 0) begin
        if (vecs[i].rdy && !vecs[i].sq) exp_fetch = exp_fetch + 1;
        if (!vecs[i].rdy) exp_stall = exp_stall + 1;
      end
      $display("vec %0d: valid=%0b instr=%08h pc=%08h pc8=%08h addr=%03h fc=%0d sc=%0d",
               i, if_valid, if_instr, if_pc, if_pc8, imem_addr, fetch_count, stall_count);
      chk($sformatf("vec%0d if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d if_instr", i), if_instr, vecs[i].exp_instr);
      chk($sformatf("vec%0d imem_addr", i), {23'd0, imem_addr}, {23'd0, vecs[i].exp_addr});
      if (vecs[i].exp_valid || i == 0) begin
        chk($sformatf("vec%0d if_pc", i), if_pc, vecs[i].exp_pc);
        chk($sformatf("vec%0d if_pc8", i), if_pc8, vecs[i].exp_pc + 32'd8);
      end
      chk_counters($sformatf("vec%0d", i), exp_fetch, exp_stall);
    end
    id_ready = 1'b1; redirect = 1'b0; squash = 1'b0;

    // Reset arriving on the same edge as a redirect must win.
    reset = 1'b1; redirect = 1'b1; redirect_target = 32'h80;
    step();
    reset = 1'b0; redirect = 1'b0;
    $display("rst+redir: valid=%0b pc=%08h addr=%03h", if_valid, if_pc, imem_addr);
    chk("rstredir if_valid", {31'd0, if_valid}, 32'd0);
    chk("rstredir imem_addr", {23'd0, imem_addr}, 32'h0);
    chk_counters("rstredir", 32'd0, 32'd0);
    step();
    chk("rstredir boot if_valid", {31'd0, if_valid}, 32'd0);
    step();
    $display("rst+redir fetch1: instr=%08h pc=%08h", if_instr, if_pc);
    chk("rstredir fetch1 if_pc", if_pc, 32'h0);
    chk("rstredir fetch1 if_instr", if_instr, 32'h2001_0005);
    step();
    $display("rst+redir fetch2: instr=%08h pc=%08h", if_instr, if_pc);
    chk("rstredir fetch2 if_pc", if_pc, 32'h4);

    // Wrap: redirect to the last word, then free run across 0.
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wrap redir-edge if_pc", if_pc, 32'h8);
    step();
    $display("wrap slot: pc=%08h addr=%03h", if_pc, imem_addr);
    chk("wrap delay slot if_pc", if_pc, 32'hC);
    chk("wrap imem_addr", {23'd0, imem_addr}, 32'h1FC);
    step();
    $display("wrap top: instr=%08h pc=%08h pc8=%08h", if_instr, if_pc, if_pc8);
    chk("wrap top if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap top if_pc8", if_pc8, 32'h4);
    chk("wrap top if_instr", if_instr, 32'hA500_01FC);
    step();
    $display("wrap zero: instr=%08h pc=%08h pc8=%08h", if_instr, if_pc, if_pc8);
    chk("wrap zero if_pc", if_pc, 32'h0);
    chk("wrap zero if_instr", if_instr, 32'h2001_0005);
    step();
    chk("wrap next if_pc", if_pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the MIPS pipeline: owns the PC/nPC pair with branch delay slot and reads instruction memory.
- Registers the fetched word plus its PC into the IF/ID latch that feeds the control unit and decode.
- It is the producer side of the instruction stream that the control unit consumes.
- Honours decode back-pressure (LE/stall), branch/jump redirects and squash requests.

Parameters:
- ADDR_W, 9: instruction memory byte-address width. The PC is 32 bits; the low ADDR_W bits drive memory.
- RESET_PC, 32'h0000_0000: PC value after reset. nPC resets to RESET_PC+4.
- NOP_WORD, 32'h0000_0000: word placed in IF/ID on reset or squash (sll $0,$0,0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  instruction memory byte address (= PC[ADDR_W-1:0]).
- imem_data  in  32  instruction word, combinational read of imem_addr.
- id_ready  in  1  decode can accept (0 = stall, load-use hazard).
- redirect  in  1  branch/jump taken, resolved in ID.
- redirect_target  in  32  taken target address.
- squash  in  1  replace the next IF/ID contents with NOP_WORD.
- if_valid  out  1  IF/ID holds a real instruction.
- if_instr  out  32  IF/ID instruction, to the control unit and register file.
- if_pc  out  32  PC of if_instr.
- if_pc8  out  32  if_pc+8, return address for jal/jalr.
- fetch_count  out  32  performance counter (see Optional Feature).
- stall_count  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset (reset=1 at posedge), overriding everything:
  - PC=RESET_PC, nPC=RESET_PC+4.
  - if_instr=NOP_WORD, if_pc=0, if_pc8=8, if_valid=0, counters=0.
  - State goes to BOOT.
- FSM states: BOOT, RUN, HOLD.
  - BOOT lasts exactly one cycle: no IF/ID load, PC unchanged. Next state is RUN.
  - RUN:
    - advance = id_ready. On advance:
      - IF/ID <= {imem_data, PC, PC+8}, if_valid<=1.
      - PC<=nPC; nPC<=redirect ? redirect_target : nPC+4.
    - If id_ready=0, go to HOLD.
  - HOLD:
    - PC, nPC and IF/ID are frozen; imem_addr stays stable.
    - Return to RUN in the cycle after id_ready=1. The load is performed on that same edge.
- Delay slot: a redirect sampled on an advance edge changes only nPC. The instruction at the old nPC (the delay slot) is fetched next, then the target. The delay slot is never squashed by this block.
- redirect while id_ready=0: ignored. ID must hold redirect until it advances.
- squash:
  - On the advance edge, IF/ID gets NOP_WORD with if_valid=0 instead of imem_data; PC/nPC still advance normally.
  - squash while stalled: IF/ID is forced to NOP/invalid immediately and PC/nPC are held.
  - squash has priority over id_ready for the IF/ID contents.
- Arithmetic: all PC math is modulo 2^32. PC wrap from 32'hFFFF_FFFC to 0 is legal. imem_addr truncates silently.
- PC[1:0] is forced to 00 on load. A misaligned redirect_target has its low 2 bits cleared.
- Latency: imem_data for address A appears on if_instr one cycle after PC=A with id_ready=1.

Optional Feature:
- Macro IF_PERF_COUNTERS_EN.
- When defined:
  - fetch_count increments on each advance edge that loads if_valid=1.
  - stall_count increments on each cycle in HOLD, or in RUN with id_ready=0.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- When not defined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset then free run: memory words 0x20010005, 0x20020003, 0x00221820 at 0/4/8, id_ready=1.
  - if_valid=0 in BOOT.
  - Then if_instr=0x20010005 with if_pc=0, if_pc8=8.
  - Next cycles show 0x20020003 (pc 4) and 0x00221820 (pc 8).
- Stall: id_ready=0 for 3 cycles while if_pc=4 → if_instr/if_pc and imem_addr constant for 3 cycles. Release → if_pc=8 on the next edge. stall_count=3 with IF_PERF_COUNTERS_EN.
- Branch with delay slot: redirect=1, target=0x40 while the beq at pc 0x10 advances → if_pc sequence 0x14 (delay slot), then 0x40, 0x44.
- Squash: squash=1 on an advance edge at pc 0x20 → if_instr=0, if_valid=0. The next fetch is pc 0x24, and fetch_count does not count the squashed slot.
- Reset mid-redirect: reset=1 on the same edge as redirect=1, target=0x80 → PC=RESET_PC, if_valid=0, no jump to 0x80 afterwards.
- Wrap: redirect_target=0xFFFF_FFFC, then free run → the fetch after 0xFFFF_FFFC is pc 0x0000_0000 and if_pc8 equals 0x4 at the wrap.
